fpu_ctrl: RTL and testbench

Sequencer for the floating-point execution units behind the main decoder's FTEXECUTE state. It classifies the FTYPE instruction and issues it to the selected unit. It waits either a fixed latency (pipelined units) or a done handshake (iterative div/sqrt), then produces the single-cycle register-write strobe and the `flpt_done` pulse the decoder busy-waits on. A watchdog guarantees `flpt_done` so the core never hangs.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_ctrl_if.sv | 29 ++
 rtl/fpu_opdec.sv | 32 +++
 rtl/fpu_ctrl.sv | 142 ++++++++++++++
 tb/tb_fpu_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and encodings for the FP sequencer and the FP datapath result mux.
package fpu_pkg;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_MUL  = 3'd2,
    CLS_DIV  = 3'd3,
    CLS_SQRT = 3'd4,
    CLS_CVT  = 3'd5,
    CLS_SGNJ = 3'd6,
    CLS_CMP  = 3'd7
  } fpu_class_t;

  localparam logic [6:0] F7Add   = 7'b0000000;
  localparam logic [6:0] F7Sub   = 7'b0000100;
  localparam logic [6:0] F7Mul   = 7'b0001000;
  localparam logic [6:0] F7Div   = 7'b0001100;
  localparam logic [6:0] F7Sqrt  = 7'b0101100;
  localparam logic [6:0] F7CvtWS = 7'b1100000;
  localparam logic [6:0] F7CvtSW = 7'b1101000;
  localparam logic [6:0] F7Sgnj  = 7'b0010000;
  localparam logic [6:0] F7MvXW  = 7'b1110000;
  localparam logic [6:0] F7MvWX  = 7'b1111000;
  localparam logic [6:0] F7Cmp   = 7'b1010000;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitLat  = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StWb       = 3'd4;

endpackage

// File: rtl/fpu_ctrl_if.sv
// Decoder/unit-facing signal bundle of the FP sequencer.
interface fpu_ctrl_if;
  import fpu_pkg::*;

  logic       start;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs2;
  logic       unit_done;
  logic       busy;
  fpu_class_t unit_sel;
  logic [6:0] op_f7;
  logic [2:0] op_f3;
  logic       unit_start;
  logic       fregwrite;
  logic       iregwrite;
  logic       flpt_done;
  logic [1:0] fpu_err;

  modport master (
    output start, funct7, funct3, rs2, unit_done,
    input  busy, unit_sel, op_f7, op_f3, unit_start, fregwrite, iregwrite, flpt_done, fpu_err
  );

  modport slave (
    input  start, funct7, funct3, rs2, unit_done,
    output busy, unit_sel, op_f7, op_f3, unit_start, fregwrite, iregwrite, flpt_done, fpu_err
  );
endinterface

// File: rtl/fpu_opdec.sv
// FTYPE instruction classifier: selects the execution unit and the destination register file.
module fpu_opdec
  import fpu_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [4:0] rs2,
  output fpu_class_t cls,
  output logic       legal,
  output logic       dest_int
);

  always_comb begin
    cls = CLS_NONE;
    case (funct7)
      F7Add, F7Sub:     cls = CLS_ADD;
      F7Mul:            cls = CLS_MUL;
      F7Div:            cls = CLS_DIV;
      F7Sqrt:           if (rs2 == 5'd0) cls = CLS_SQRT;
      // rs2 selects signed/unsigned int; only 0 and 1 exist
      F7CvtWS, F7CvtSW: if (rs2[4:1] == 4'd0) cls = CLS_CVT;
      F7Sgnj:           if (funct3 <= 3'b010) cls = CLS_SGNJ;
      F7MvXW, F7MvWX:   if (funct3 == 3'b000) cls = CLS_SGNJ;
      F7Cmp:            if (funct3 <= 3'b010) cls = CLS_CMP;
      default:          cls = CLS_NONE;
    endcase
  end

  assign legal    = (cls != CLS_NONE);
  assign dest_int = (funct7 == F7Cmp) || (funct7 == F7CvtWS) || (funct7 == F7MvXW);

endmodule

// File: rtl/fpu_ctrl.sv
// FP execution sequencer: issues an FTYPE op, waits fixed latency or unit_done, then writes back.
module fpu_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_CVT  = 1,
  parameter int unsigned LAT_SGNJ = 0,
  parameter int unsigned LAT_CMP  = 0,
  parameter int unsigned MAX_WAIT = 64
) (
  input logic       clk,
  input logic       rstn,
  fpu_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic [2:0]       state_q, state_d;
  fpu_class_t       cls_q, cls_d, dec_cls;
  logic [6:0]       f7_q, f7_d;
  logic [2:0]       f3_q, f3_d;
  logic             dest_int_q, dest_int_d, dec_dest_int, dec_legal;
  logic             illegal_q, illegal_d, timeout_q, timeout_d;
  logic [3:0]       cnt_q, cnt_d, lat;
  logic [WaitW-1:0] wcnt_q, wcnt_d;

  fpu_opdec u_opdec (
    .funct7   (bus.funct7),
    .funct3   (bus.funct3),
    .rs2      (bus.rs2),
    .cls      (dec_cls),
    .legal    (dec_legal),
    .dest_int (dec_dest_int)
  );

  always_comb begin
    case (cls_q)
      CLS_ADD:  lat = 4'(LAT_ADD);
      CLS_MUL:  lat = 4'(LAT_MUL);
      CLS_CVT:  lat = 4'(LAT_CVT);
      CLS_SGNJ: lat = 4'(LAT_SGNJ);
      CLS_CMP:  lat = 4'(LAT_CMP);
      default:  lat = 4'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    f7_d       = f7_q;
    f3_d       = f3_q;
    dest_int_d = dest_int_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          cls_d      = dec_cls;
          f7_d       = bus.funct7;
          f3_d       = bus.funct3;
          dest_int_d = dec_dest_int;
          if (dec_legal) begin
            state_d = StIssue;
          end else begin
            illegal_d = 1'b1;
            state_d   = StWb;
          end
        end
      end
      StIssue: begin
        if (cls_q == CLS_DIV || cls_q == CLS_SQRT) begin
          wcnt_d  = '0;
          state_d = StWaitDone;
        end else if (lat <= 4'd1) begin
          state_d = StWb;
        end else begin
          // ISSUE and the final WAITLAT cycle account for two of the latency cycles
          cnt_d   = lat - 4'd2;
          state_d = StWaitLat;
        end
      end
      StWaitLat: begin
        if (cnt_q == 4'd0) state_d = StWb;
        else cnt_d = cnt_q - 4'd1;
      end
      StWaitDone: begin
        if (bus.unit_done) begin
          state_d = StWb;
        end else if (wcnt_q == WaitW'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StWb;
        end else begin
          wcnt_d = wcnt_q + WaitW'(1);
        end
      end
      StWb: begin
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cls_q      <= CLS_NONE;
      f7_q       <= 7'd0;
      f3_q       <= 3'd0;
      dest_int_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= 4'd0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      f7_q       <= f7_d;
      f3_q       <= f3_d;
      dest_int_q <= dest_int_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.unit_start = (state_q == StIssue);
  assign bus.flpt_done  = (state_q == StWb);
  assign bus.fregwrite  = bus.flpt_done & ~illegal_q & ~timeout_q & ~dest_int_q;
  assign bus.iregwrite  = bus.flpt_done & ~illegal_q & ~timeout_q & dest_int_q;
  assign bus.fpu_err    = bus.flpt_done ? {timeout_q, illegal_q} : 2'b00;
  assign bus.unit_sel   = cls_q;
  assign bus.op_f7      = f7_q;
  assign bus.op_f3      = f3_q;

endmodule

// File: tb/tb_fpu_ctrl.sv
// Directed and randomized checks of fpu_ctrl against a table-driven reference model.
module tb_fpu_ctrl;
  import fpu_pkg::*;

  localparam int LatAdd  = 2;
  localparam int LatMul  = 2;
  localparam int LatCvt  = 1;
  localparam int LatSgnj = 0;
  localparam int LatCmp  = 0;
  localparam int MaxWait = 64;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3max;
    logic [4:0] rs2max;
    fpu_class_t cls;
    int         lat;     // -1: iterative unit with done handshake
    logic       to_int;
  } row_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;
  row_t rows[11];

  always #5 clk = ~clk;

  fpu_ctrl_if bus ();

  fpu_ctrl #(
    .LAT_ADD  (LatAdd),
    .LAT_MUL  (LatMul),
    .LAT_CVT  (LatCvt),
    .LAT_SGNJ (LatSgnj),
    .LAT_CMP  (LatCmp),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.unit_start, bus.fregwrite, bus.iregwrite, bus.flpt_done,
                bus.fpu_err, bus.unit_sel, bus.op_f7, bus.op_f3});
  endfunction

  function automatic void model(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs2,
                                output fpu_class_t cls, output bit legal, output bit to_int,
                                output int lat);
    cls = CLS_NONE; legal = 1'b0; to_int = 1'b0; lat = 0;
    foreach (rows[i]) begin
      if (rows[i].f7 == f7 && f3 <= rows[i].f3max && rs2 <= rows[i].rs2max) begin
        cls = rows[i].cls; legal = 1'b1; to_int = rows[i].to_int; lat = rows[i].lat;
      end
    end
  endfunction

  // done_at: cycle after acceptance in which unit_done is pulsed (0 = never)
  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs2,
                        input int done_at);
    fpu_class_t ecls;
    bit legal, to_int, tmo;
    int lat, wb;
    model(f7, f3, rs2, ecls, legal, to_int, lat);
    tmo = 1'b0;
    if (!legal) wb = 1;
    else if (lat < 0) begin
      if (done_at >= 2 && done_at <= MaxWait + 1) wb = done_at + 1;
      else begin wb = MaxWait + 2; tmo = 1'b1; end
    end else wb = 1 + ((lat < 1) ? 1 : lat);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct7 = f7; bus.funct3 = f3; bus.rs2 = rs2; bus.unit_done = 1'b0;
    @(negedge clk);
    chk("idle_at_accept", 32'(bus.busy), 32'd0);
    for (int k = 1; k <= wb; k++) begin
      @(posedge clk); #1;
      bus.unit_done = (done_at == k);
      @(negedge clk);
      chk("unit_start", 32'(bus.unit_start), 32'(k == 1 && legal));
      chk("flpt_done", 32'(bus.flpt_done), 32'(k == wb));
      chk("busy", 32'(bus.busy), 32'd1);
      if (k == wb) begin
        chk("fregwrite", 32'(bus.fregwrite), 32'(legal && !tmo && !to_int));
        chk("iregwrite", 32'(bus.iregwrite), 32'(legal && !tmo && to_int));
        chk("fpu_err", 32'(bus.fpu_err), 32'({tmo, !legal}));
        if (legal) begin
          chk("unit_sel", 32'(bus.unit_sel), 32'(ecls));
          chk("op_f7", 32'(bus.op_f7), 32'(f7));
          chk("op_f3", 32'(bus.op_f3), 32'(f3));
        end
      end else begin
        chk("early_write", 32'({bus.fregwrite, bus.iregwrite}), 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.unit_done = 1'b0;
    @(negedge clk);
    chk("idle_after", 32'({bus.busy, bus.flpt_done}), 32'd0);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
  endtask

  task automatic idle_done();
    @(posedge clk); #1; bus.unit_done = 1'b1;
    @(negedge clk);
    chk("idle_done_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1; bus.unit_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", 32'({bus.busy, bus.flpt_done, bus.fregwrite}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    logic [6:0] f7;
    rows = '{
      '{7'b0000000, 3'd7, 5'd31, CLS_ADD,  LatAdd,  1'b0},
      '{7'b0000100, 3'd7, 5'd31, CLS_ADD,  LatAdd,  1'b0},
      '{7'b0001000, 3'd7, 5'd31, CLS_MUL,  LatMul,  1'b0},
      '{7'b0001100, 3'd7, 5'd31, CLS_DIV,  -1,      1'b0},
      '{7'b0101100, 3'd7, 5'd0,  CLS_SQRT, -1,      1'b0},
      '{7'b1100000, 3'd7, 5'd1,  CLS_CVT,  LatCvt,  1'b1},
      '{7'b1101000, 3'd7, 5'd1,  CLS_CVT,  LatCvt,  1'b0},
      '{7'b0010000, 3'd2, 5'd31, CLS_SGNJ, LatSgnj, 1'b0},
      '{7'b1110000, 3'd0, 5'd31, CLS_SGNJ, LatSgnj, 1'b1},
      '{7'b1111000, 3'd0, 5'd31, CLS_SGNJ, LatSgnj, 1'b0},
      '{7'b1010000, 3'd2, 5'd31, CLS_CMP,  LatCmp,  1'b1}
    };
    bus.start = 1'b0; bus.funct7 = 7'd0; bus.funct3 = 3'd0; bus.rs2 = 5'd0;
    bus.unit_done = 1'b0;
    rstn = 1'b0;
    #1;
    chk("reset_outputs", outs(), 32'd0);
    #20;
    @(posedge clk); #1; rstn = 1'b1;

    run_op(7'b0000000, 3'b000, 5'd0, 0);    // fadd
    run_op(7'b1010000, 3'b000, 5'd0, 0);    // fle
    run_op(7'b0001100, 3'b000, 5'd0, 11);   // fdiv, done 10 cycles after unit_start
    idle_done();
    run_op(7'b0101100, 3'b000, 5'd0, 0);    // fsqrt, watchdog expires
    run_op(7'b0101100, 3'b000, 5'd0, MaxWait + 1);  // done on expiry cycle
    run_op(7'b0000011, 3'b000, 5'd0, 0);    // illegal funct7
    run_op(7'b0101100, 3'b000, 5'd1, 0);    // fsqrt with rs2=1
    run_op(7'b0010000, 3'b011, 5'd0, 0);    // fsgnj funct3 out of range
    run_op(7'b1100000, 3'b001, 5'd1, 0);    // fcvt.w.s to integer
    run_op(7'b0001000, 3'b000, 5'd0, 0);    // fmul

    // Reset during WAITLAT of fmul
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct7 = 7'b0001000; bus.funct3 = 3'b000; bus.rs2 = 5'd0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_issue", 32'(bus.unit_start), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_waitlat", 32'({bus.busy, bus.unit_start, bus.flpt_done}), 32'b100);
    #1; rstn = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    idle_done();
    run_op(7'b0000000, 3'b000, 5'd0, 0);

    for (int n = 0; n < 30; n++) begin
      int idx;
      idx = int'($urandom_range(0, 12));
      if (idx < 11) f7 = rows[idx].f7;
      else f7 = 7'($urandom);
      run_op(f7, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
             int'($urandom_range(0, MaxWait + 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
